// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: DMType codes, LSU FSM encoding
// and memory byte-enable width, used by the control decoder and the LSU.
package riscv_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // 011, 110 and 111 fall through to word
  function automatic size_e dm_size(
    input logic [2:0] dm
  );
    size_e sz;
    unique case (1'b1)
      (dm == DM_B) || (dm == DM_BU): sz = SZ_B;
      (dm == DM_H) || (dm == DM_HU): sz = SZ_H;
      default:                       sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic [1:0] eff_off(
    input size_e      sz,
    input logic [1:0] a
  );
    logic [1:0] o;
    unique case (sz)
      SZ_B:    o = a;
      SZ_H:    o = {a[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] dm,
    input logic [1:0] a
  );
    logic m;
    unique case (dm_size(dm))
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      default: m = |a;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store replication + byte enables (LOAD=0)
// or load lane select + sign/zero extension (LOAD=1).
module lsu_align
  import riscv_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [2:0]      dm_type,
  input  logic [1:0]      off,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  output logic [BE_W-1:0] be
);

  size_e       sz;
  logic        uns;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  assign sz  = dm_size(dm_type);
  assign uns = dm_type[2];

  always_comb begin
    b_lane = din[7:0];
    unique case (off)
      2'd0:    b_lane = din[7:0];
      2'd1:    b_lane = din[15:8];
      2'd2:    b_lane = din[23:16];
      default: b_lane = din[31:24];
    endcase
    h_lane = off[1] ? din[31:16] : din[15:0];
  end

  always_comb begin
    dout = din;
    be   = 4'b1111;
    if (LOAD) begin
      unique case (sz)
        SZ_B:
          dout = {{24{~uns & b_lane[7]}}, b_lane};
        SZ_H:
          dout = {{16{~uns & h_lane[15]}}, h_lane};
        default:
          dout = din;
      endcase
    end else begin
      unique case (sz)
        SZ_B: begin
          be   = 4'b0001 << off;
          dout = {4{din[7:0]}};
        end
        SZ_H: begin
          be   = off[1] ? 4'b1100 : 4'b0011;
          dout = {2{din[15:0]}};
        end
        default: begin
          be   = 4'b1111;
          dout = din;
        end
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE->BUS->DONE memory FSM, one access at a time.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  input  logic            mem_we,
  input  logic            mem_re,
  input  logic [2:0]      dm_type,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic            stall,
  output logic            done,
  output logic [31:0]     rdata,
  output logic            misalign_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [31:0]     bus_wdata,
  input  logic            bus_ready,
  input  logic [31:0]     bus_rdata
);

  logic [1:0]      state;
  logic            accept;
  logic            mis;
  logic [1:0]      off;
  logic            lat_we;
  logic [2:0]      lat_dm;
  logic [1:0]      lat_off;
  logic [31:0]     st_data;
  logic [31:0]     ld_data;
  logic [BE_W-1:0] st_be;
  logic [BE_W-1:0] ld_be;

  assign accept = (state == ST_IDLE) & req_valid
                & (mem_we | mem_re);
  assign stall  = accept | (state == ST_BUS);
  // Misaligned bits are dropped here; trapping is decided by mis
  assign off    = eff_off(dm_size(dm_type), addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign mis          = misaligned(dm_type, addr[1:0]);
  assign misalign_err = err_q;

  always_ff @(posedge clk) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= accept & mis;
  end
`else
  assign mis          = 1'b0;
  assign misalign_err = 1'b0;
`endif

  lsu_align #(.LOAD(1'b0)) u_st_align (
    .dm_type (dm_type),
    .off     (off),
    .din     (wdata),
    .dout    (st_data),
    .be      (st_be)
  );

  lsu_align #(.LOAD(1'b1)) u_ld_align (
    .dm_type (lat_dm),
    .off     (lat_off),
    .din     (bus_rdata),
    .dout    (ld_data),
    .be      (ld_be)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      done      <= 1'b0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_dm    <= '0;
      lat_off   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            lat_we  <= mem_we;
            lat_dm  <= dm_type;
            lat_off <= off;
            if (mis) begin
              state <= ST_DONE;
              done  <= 1'b1;
              rdata <= '0;
            end else begin
              state     <= ST_BUS;
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= mem_we ? st_be : ld_be;
              bus_wdata <= mem_we ? st_data : '0;
            end
          end
        end
        ST_BUS: begin
          if (bus_ready) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            rdata   <= lat_we ? '0 : ld_data;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized
// transactions against a byte-arithmetic reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [2:0]  dm_type = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .dm_type      (dm_type),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .misalign_err (misalign_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] dm);
    if (dm == 3'd0 || dm == 3'd4) return 1;
    if (dm == 3'd1 || dm == 3'd5) return 2;
    return 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(
    input logic        we,
    input logic        re,
    input logic [2:0]  dm,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          waits
  );
    int          n;
    int          off;
    logic        trap;
    logic [31:0] mask;
    logic [31:0] lane;
    logic [31:0] wexp;
    logic [31:0] rexp;
    logic [3:0]  be;
    n    = nbytes(dm);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (int'(a[1:0]) % n) != 0;
`endif
    off  = int'(a[1:0]) / n * n;
    mask = 32'((64'd1 << (8 * n)) - 64'd1);
    be   = 4'(((1 << n) - 1) << off);
    wexp = '0;
    for (int k = 0; k < 4; k += n)
      wexp |= (wd & mask) << (8 * k);
    lane = (rd >> (8 * off)) & mask;
    if ((dm == 3'd0 || dm == 3'd1) && lane[8 * n - 1])
      lane |= ~mask;
    rexp = (we || trap) ? 32'd0 : lane;

    req_valid = 1'b1;
    mem_we    = we;
    mem_re    = re;
    dm_type   = dm;
    addr      = a;
    wdata     = wd;
    bus_ready = 1'b0;
    #1;
    check("stall_accept", stall, 1);
    tick();
    if (trap) begin
      check("trap_done", done, 1);
      check("trap_err", misalign_err, 1);
      check("trap_no_req", bus_req, 0);
      check("trap_stall", stall, 0);
      check("trap_rdata", rdata, 0);
    end else begin
      check("req", bus_req, 1);
      check("addr", bus_addr, a & ~32'd3);
      check("be", bus_be, we ? be : 4'hf);
      check("we", bus_we, we);
      if (we) check("wdata", bus_wdata, wexp);
      check("stall_bus", stall, 1);
      check("no_done", done, 0);
      for (int i = 0; i < waits; i++) begin
        bus_rdata = $urandom;
        tick();
        check("wait_req", bus_req, 1);
        check("wait_addr", bus_addr, a & ~32'd3);
        check("wait_be", bus_be, we ? be : 4'hf);
        if (we) check("wait_wdata", bus_wdata, wexp);
        check("wait_stall", stall, 1);
        check("wait_done", done, 0);
      end
      bus_ready = 1'b1;
      bus_rdata = rd;
      tick();
      bus_rdata = $urandom;
      check("done", done, 1);
      check("err", misalign_err, 0);
      check("rdata", rdata, rexp);
      check("req_drop", bus_req, 0);
      check("stall_done", stall, 0);
    end
    tick();
    req_valid = 1'b0;
    bus_ready = 1'b0;
    check("done_pulse", done, 0);
    check("no_reaccept", bus_req, 0);
    check("err_clear", misalign_err, 0);
    check("rdata_hold", rdata, rexp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_be", bus_be, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", misalign_err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_stall", stall, 0);
    rstn = 1'b1;
    tick();

    req_valid = 1'b1;
    #1;
    check("noop_stall", stall, 0);
    tick();
    check("noop_req", bus_req, 0);
    req_valid = 1'b0;

    run(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
    run(1, 0, 3'b000, 32'h103, 32'h000000A5, 0, 0);
    check("sb_be_lit", bus_be, 4'b1000);
    check("sb_wd_lit", bus_wdata, 32'hA5A5A5A5);
    run(0, 1, 3'b000, 32'h202, 0, 32'h12F45678, 0);
    check("lb_lit", rdata, 32'hFFFFFFF4);
    run(0, 1, 3'b100, 32'h202, 0, 32'h12F45678, 1);
    check("lbu_lit", rdata, 32'h000000F4);
    run(0, 1, 3'b001, 32'h202, 0, 32'h12F45678, 0);
    check("lh_lit", rdata, 32'h000012F4);
    run(1, 1, 3'b001, 32'h206, 32'h0000BEEF, 0, 3);
    run(0, 1, 3'b010, 32'h101, 0, 32'hCAFEF00D, 2);

    req_valid = 1'b1;
    mem_we    = 1'b1;
    mem_re    = 1'b0;
    dm_type   = 3'b010;
    addr      = 32'h100;
    wdata     = 32'h11223344;
    tick();
    req_valid = 1'b0;
    check("mid_req", bus_req, 1);
    rstn = 1'b0;
    tick();
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_done", done, 0);
    rstn = 1'b1;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("post_rst_done", done, 0);
    check("post_rst_req", bus_req, 0);
    run(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);

    for (int t = 0; t < 60; t++) begin
      logic we;
      we = 1'($urandom);
      run(we, we ? 1'($urandom) : 1'b1,
          3'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
